// File: rtl/mul_seq.sv
// mul_seq: multi-cycle RV32M MUL (low XLEN bits of rs1*rs2) built as a
// shift-add loop that borrows the shared execute-stage ALU for every add.
// The ALU is driven with acc (op1) and the shifted multiplicand (op2) and
// its combinational sum is folded back into the accumulator when the
// current multiplier bit is set.
//
// Optional build macro: MUL_SEQ_EARLY_EXIT_EN
//   When defined, RUN terminates as soon as the remaining multiplier is
//   zero. The product is the same in both builds; only latency changes.
module mul_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] alu_op1,
  output logic [XLEN-1:0] alu_op2,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] mcand_r;
  logic [XLEN-1:0] mplier_r;
  logic [XLEN-1:0] result_r;
  logic [XLEN-1:0] acc_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic            busy_r;
  logic            done_r;
  logic            last_s;
  logic            early_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign alu_op1  = acc_r;
  assign alu_op2  = mcand_r;
  assign alu_ctrl = 4'b0000;

  // Accumulate decision and loop-termination conditions for this RUN cycle.
  always_comb begin
    acc_nxt_s = acc_r;
    if (mplier_r[0]) begin
      acc_nxt_s = alu_result;
    end else begin
      acc_nxt_s = acc_r;
    end
    last_s = (cnt_r == CNT_LAST);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    early_s = (mplier_r == ZERO_X);
`else
    early_s = 1'b0;
`endif
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (early_s || last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: operand capture, shift-add iteration, result and handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r    <= ZERO_X;
      mcand_r  <= ZERO_X;
      mplier_r <= ZERO_X;
      result_r <= ZERO_X;
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            acc_r    <= ZERO_X;
            mcand_r  <= rs1;
            mplier_r <= rs2;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
          end
        end
        RUN: begin
          if (early_s) begin
            // Nothing left to add: freeze the datapath and publish acc.
            result_r <= acc_r;
            done_r   <= 1'b1;
          end else begin
            acc_r    <= acc_nxt_s;
            mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
            cnt_r    <= cnt_r + CNT_ONE;
            if (last_s) begin
              result_r <= acc_nxt_s;
              done_r   <= 1'b1;
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed-vector scoreboard bench for mul_seq.
// The bench models the shared ALU as a combinational adder. Stimulus pushes
// the expected product and the edge count at which done must be seen; a
// monitor pops and compares on every done pulse.
// Cycle numbering here counts rising edges: if start is accepted at edge k,
// done is observed in the interval following edge k+XLEN (k+1 with an empty
// multiplier in the early-exit build).
module tb_mul_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] alu_op1;
  logic [XLEN-1:0] alu_op2;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [XLEN-1:0] exp_res_q[$];
  int              exp_cyc_q[$];

  mul_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result)
  );

  // Shared ALU model: only ADD is exercised by the sequencer.
  assign alu_result = (alu_ctrl == 4'b0000) ? (alu_op1 + alu_op2) : 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected RUN length for a given multiplier.
  function automatic int run_len(input logic [XLEN-1:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    int hb;
    if (b == 0) return 1;
    hb = 0;
    for (int i = 0; i < XLEN; i++) if (b[i]) hb = i;
    return (hb + 2 < XLEN) ? hb + 2 : XLEN;
`else
    return XLEN;
`endif
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp);
    @(negedge clk);
    start = 1'b1;
    rs1 = a;
    rs2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(cyc + run_len(b));
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && exp_res_q.size() != 0; i++) @(posedge clk);
    if (exp_res_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding, expected 0", exp_res_q.size());
      exp_res_q.delete();
      exp_cyc_q.delete();
    end
    @(posedge clk);
    #1;
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (exp_res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 at edge %0d, expected no pulse", cyc);
        end else begin
          logic [XLEN-1:0] er;
          int              ec;
          er = exp_res_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", result, er);
          check("done_cycle", cyc, ec);
          check("busy_at_done", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  initial begin
    int k;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'h0000_0000);
    check("rst_alu_op1", alu_op1, 32'h0000_0000);
    check("rst_alu_op2", alu_op2, 32'h0000_0000);
    check("alu_ctrl", {28'd0, alu_ctrl}, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;

    // Basic and arithmetic corner vectors.
    run_op(32'd7, 32'd6, 32'd42);                       wait_idle();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001); wait_idle();
    run_op(32'h8000_0000, 32'd2, 32'h0000_0000);        wait_idle();
    run_op(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);        wait_idle();
    run_op(32'h0000_1234, 32'd0, 32'h0000_0000);        wait_idle();
    run_op(32'd0, 32'd5, 32'h0000_0000);                wait_idle();
    run_op(32'd9, 32'h0000_0010, 32'h0000_0090);        wait_idle();

    // start re-pulsed while busy must be ignored.
    run_op(32'd3, 32'h8000_0001, 32'h8000_0003);
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    rs1 = 32'd1;
    rs2 = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(posedge clk);

    // start held high: two accepts, 34 edges apart.
    @(negedge clk);
    start = 1'b1;
    rs1 = 32'd5;
    rs2 = 32'h8000_0000;
    @(posedge clk);
    #1;
    k = cyc;
    exp_res_q.push_back(32'h8000_0000);
    exp_cyc_q.push_back(k + 32);
    exp_res_q.push_back(32'h8000_0000);
    exp_cyc_q.push_back(k + 66);
    repeat (65) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (40) @(posedge clk);

    // Reset in the middle of an operation.
    run_op(32'd7, 32'h8000_0000, 32'h8000_0000);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_result", result, 32'h0000_0000);
    exp_res_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd3, 32'd4, 32'd12);
    wait_idle();
    repeat (40) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
